ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 32 +++
 rtl/arb_hold_counter.sv | 41 ++++
 rtl/ram_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_ram_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared defaults, FSM state and requester-id types for the
// RAM arbiter. Optional feature macro used by ram_arbiter: ARB_ROUND_ROBIN_EN.
package ram_arb_pkg;

  localparam int DEFAULT_WORD_SIZE    = 8;
  localparam int DEFAULT_ADDRESS_SIZE = 5;
  localparam int DEFAULT_MAX_HOLD     = 16;

  // Ownership FSM; the grants are decoded straight from this register.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_LD  = 2'd1,
    OWN_CPU = 2'd2
  } arb_state_t;

  // Identifies one of the two requesters (loader or CPU).
  typedef enum logic {
    REQ_LD  = 1'b0,
    REQ_CPU = 1'b1
  } req_id_t;

  // The requester that is not the given one.
  function automatic req_id_t other_requester(input req_id_t id);
    return (id == REQ_LD) ? REQ_CPU : REQ_LD;
  endfunction

  // Width of a counter that must reach max_hold-1 (at least one bit).
  function automatic int hold_count_width(input int max_hold);
    return (max_hold > 2) ? $clog2(max_hold) : 1;
  endfunction

endpackage

// File: rtl/arb_hold_counter.sv
// arb_hold_counter: counts cycles an owner keeps the RAM while the other
// requester waits, saturating at MAX_HOLD-1, and flags expiry of the hold
// budget. MAX_HOLD of 0 disables expiry entirely.
module arb_hold_counter
  import ram_arb_pkg::*;
#(
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW      = hold_count_width(MAX_HOLD);
  localparam int SAT_INT = (MAX_HOLD == 0) ? ((2 ** CW) - 1) : (MAX_HOLD - 1);
  localparam logic [CW-1:0] SAT = SAT_INT[CW-1:0];

  logic [CW-1:0] count;

  // Saturating wait counter, cleared whenever the arbiter heads to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && (count != SAT)) begin
      count <= count + CW'(1);
    end
  end

  // Expiry fires during the waiting cycle in which the budget is used up.
  always_comb begin
    expired = 1'b0;
    if ((MAX_HOLD != 0) && count_en && (count == SAT)) begin
      expired = 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester (loader / CPU) ownership arbiter for a shared
// single RAM, replacing tri-state sharing with a registered-grant mux.
// Ownership always passes through IDLE; a long hold is preempted after
// MAX_HOLD waiting cycles and the waiter is then served first.
// Optional feature: define ARB_ROUND_ROBIN_EN to resolve simultaneous
// requests in favour of the requester not served last (default build uses
// fixed loader priority).
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int WORD_SIZE    = DEFAULT_WORD_SIZE,
  parameter int ADDRESS_SIZE = DEFAULT_ADDRESS_SIZE,
  parameter int MAX_HOLD     = DEFAULT_MAX_HOLD
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ld_req,
  input  logic                    cpu_req,
  output logic                    ld_gnt,
  output logic                    cpu_gnt,
  input  logic                    ld_w,
  input  logic [ADDRESS_SIZE-1:0] ld_waddr,
  input  logic [WORD_SIZE-1:0]    ld_wdata,
  input  logic [ADDRESS_SIZE-1:0] ld_raddr,
  input  logic                    cpu_w,
  input  logic [ADDRESS_SIZE-1:0] cpu_waddr,
  input  logic [WORD_SIZE-1:0]    cpu_wdata,
  input  logic [ADDRESS_SIZE-1:0] cpu_raddr,
  output logic                    ram_w,
  output logic [ADDRESS_SIZE-1:0] ram_waddr,
  output logic [WORD_SIZE-1:0]    ram_wdata,
  output logic [ADDRESS_SIZE-1:0] ram_raddr,
  output logic                    cpu_en,
  output logic                    preempt
);

  arb_state_t state;
  arb_state_t next_state;
  arb_state_t both_pick;

  logic    owner_req;
  logic    other_req;
  logic    hold_count_en;
  logic    hold_clear;
  logic    hold_expired;
  logic    preempt_now;
  logic    favor_valid;
  req_id_t favor_id;

`ifdef ARB_ROUND_ROBIN_EN
  req_id_t last_owner;
`endif

  // Request lines of the current owner and of the requester kept waiting.
  always_comb begin
    owner_req = 1'b0;
    other_req = 1'b0;
    case (state)
      OWN_LD: begin
        owner_req = ld_req;
        other_req = cpu_req;
      end
      OWN_CPU: begin
        owner_req = cpu_req;
        other_req = ld_req;
      end
      default: begin
        owner_req = 1'b0;
        other_req = 1'b0;
      end
    endcase
  end

  assign hold_count_en = (state != IDLE) && other_req;

  arb_hold_counter #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (hold_clear),
    .count_en (hold_count_en),
    .expired  (hold_expired)
  );

  // A voluntary release in the same cycle is not a forced release.
  assign preempt_now = hold_expired && owner_req;
  assign preempt     = preempt_now;

  // Winner when both requesters ask at once from IDLE.
`ifdef ARB_ROUND_ROBIN_EN
  assign both_pick = (last_owner == REQ_LD) ? OWN_CPU : OWN_LD;
`else
  assign both_pick = OWN_LD;
`endif

  // Next-state arbitration; a pending preemption favour beats priority.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (favor_valid && (favor_id == REQ_LD) && ld_req) begin
          next_state = OWN_LD;
        end else if (favor_valid && (favor_id == REQ_CPU) && cpu_req) begin
          next_state = OWN_CPU;
        end else if (ld_req && cpu_req) begin
          next_state = both_pick;
        end else if (ld_req) begin
          next_state = OWN_LD;
        end else if (cpu_req) begin
          next_state = OWN_CPU;
        end
      end
      OWN_LD, OWN_CPU: begin
        if (!owner_req || preempt_now) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign hold_clear = (next_state == IDLE);

  // Ownership state register; reset drops any grant immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Remember, for the single IDLE cycle after a preemption, who was waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      favor_valid <= 1'b0;
      favor_id    <= REQ_LD;
    end else begin
      favor_valid <= preempt_now;
      if (preempt_now) begin
        favor_id <= other_requester((state == OWN_LD) ? REQ_LD : REQ_CPU);
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Track the most recently granted requester for round-robin tie breaks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_owner <= REQ_CPU;
    end else if ((state == IDLE) && (next_state == OWN_LD)) begin
      last_owner <= REQ_LD;
    end else if ((state == IDLE) && (next_state == OWN_CPU)) begin
      last_owner <= REQ_CPU;
    end
  end
`endif

  assign ld_gnt  = (state == OWN_LD);
  assign cpu_gnt = (state == OWN_CPU);
  assign cpu_en  = cpu_gnt;

  // RAM port mux: the owner drives everything, IDLE drives zeros so a
  // non-owner write can never reach the RAM.
  always_comb begin
    ram_w     = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    ram_raddr = '0;
    case (state)
      OWN_LD: begin
        ram_w     = ld_w;
        ram_waddr = ld_waddr;
        ram_wdata = ld_wdata;
        ram_raddr = ld_raddr;
      end
      OWN_CPU: begin
        ram_w     = cpu_w;
        ram_waddr = cpu_waddr;
        ram_wdata = cpu_wdata;
        ram_raddr = cpu_raddr;
      end
      default: begin
        ram_w     = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        ram_raddr = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: self-checking bench for ram_arbiter with MAX_HOLD=4.
// A behavioural RAM sits on the muxed port; expected writes and read-back
// values are queued when stimulus is driven and compared when the DUT acts.
module tb_ram_arbiter;

  localparam int WS = 8;
  localparam int AS = 5;
  localparam int MH = 4;

  typedef struct {
    logic [AS-1:0] addr;
    logic [WS-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_req, cpu_req, ld_gnt, cpu_gnt;
  logic          ld_w, cpu_w, ram_w, cpu_en, preempt;
  logic [AS-1:0] ld_waddr, ld_raddr, cpu_waddr, cpu_raddr, ram_waddr, ram_raddr;
  logic [WS-1:0] ld_wdata, cpu_wdata, ram_wdata;

  logic [WS-1:0] mem [0:(1<<AS)-1];
  wr_t           wr_q[$];
  logic [WS-1:0] rd_q[$];
  wr_t           exp_wr;
  logic          exp_ld, exp_cpu;

  int assert_count = 0;
  int fail_count   = 0;

  always #5 clk = ~clk;

  ram_arbiter #(
    .WORD_SIZE    (WS),
    .ADDRESS_SIZE (AS),
    .MAX_HOLD     (MH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ld_req    (ld_req),
    .cpu_req   (cpu_req),
    .ld_gnt    (ld_gnt),
    .cpu_gnt   (cpu_gnt),
    .ld_w      (ld_w),
    .ld_waddr  (ld_waddr),
    .ld_wdata  (ld_wdata),
    .ld_raddr  (ld_raddr),
    .cpu_w     (cpu_w),
    .cpu_waddr (cpu_waddr),
    .cpu_wdata (cpu_wdata),
    .cpu_raddr (cpu_raddr),
    .ram_w     (ram_w),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_raddr (ram_raddr),
    .cpu_en    (cpu_en),
    .preempt   (preempt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic l, input logic c);
    ld_req  = l;
    cpu_req = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle loader write; the expected RAM write is queued up front.
  task automatic ldWrite(input logic [AS-1:0] addr, input logic [WS-1:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    wr_q.push_back(e);
    ld_w     = 1'b1;
    ld_waddr = addr;
    ld_wdata = data;
    tick();
    ld_w = 1'b0;
  endtask

  task automatic readCheck(input string tag, input bit use_cpu,
                           input logic [AS-1:0] addr, input logic [WS-1:0] expected);
    if (use_cpu) cpu_raddr = addr;
    else ld_raddr = addr;
    rd_q.push_back(expected);
    #1;
    checkOutput(tag, 32'(mem[ram_raddr]), 32'(rd_q.pop_front()));
  endtask

  // RAM model on the muxed port; every write must match a queued expectation.
  always @(negedge clk) begin
    if (ram_w === 1'b1) begin
      checkOutput("write_expected", 32'(wr_q.size() > 0), 32'd1);
      if (wr_q.size() > 0) begin
        exp_wr = wr_q.pop_front();
        checkOutput("write_addr", 32'(ram_waddr), 32'(exp_wr.addr));
        checkOutput("write_data", 32'(ram_wdata), 32'(exp_wr.data));
      end
      mem[ram_waddr] = ram_wdata;
    end
  end

  initial begin
    for (int i = 0; i < (1 << AS); i++) mem[i] = '0;
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0);
    ld_w = 1'b1; ld_waddr = 5'd5; ld_wdata = 8'h21; ld_raddr = 5'd3;
    cpu_w = 1'b0; cpu_waddr = '0; cpu_wdata = '0; cpu_raddr = 5'd2;

    // Reset holds everything idle even with a live request on the inputs.
    tick();
    tick();
    checkOutput("rst_ld_gnt",    32'(ld_gnt),    32'd0);
    checkOutput("rst_cpu_gnt",   32'(cpu_gnt),   32'd0);
    checkOutput("rst_cpu_en",    32'(cpu_en),    32'd0);
    checkOutput("rst_preempt",   32'(preempt),   32'd0);
    checkOutput("rst_ram_w",     32'(ram_w),     32'd0);
    checkOutput("rst_ram_waddr", 32'(ram_waddr), 32'd0);
    checkOutput("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    checkOutput("rst_ram_raddr", 32'(ram_raddr), 32'd0);

    applyStimulus(1'b0, 1'b0);
    ld_w = 1'b0;
    #2 reset = 1'b1;
    tick();
    checkOutput("idle_ld_gnt", 32'(ld_gnt), 32'd0);

    // Loader preload with one-cycle grant latency.
    applyStimulus(1'b1, 1'b0);
    #1 checkOutput("ld_gnt_before_edge", 32'(ld_gnt), 32'd0);
    tick();
    checkOutput("preload_ld_gnt", 32'(ld_gnt), 32'd1);
    checkOutput("preload_cpu_en", 32'(cpu_en), 32'd0);
    ldWrite(5'd0,  8'b000_01010);
    ldWrite(5'd1,  8'b000_10100);
    ldWrite(5'd10, 8'd3);
    ldWrite(5'd11, 8'd7);
    ldWrite(5'd20, 8'd4);
    readCheck("read_0",  1'b0, 5'd0,  8'd10);
    readCheck("read_1",  1'b0, 5'd1,  8'd20);
    readCheck("read_10", 1'b0, 5'd10, 8'd3);
    readCheck("read_11", 1'b0, 5'd11, 8'd7);
    readCheck("read_20", 1'b0, 5'd20, 8'd4);

    // CPU write without a grant must not reach the RAM.
    cpu_w = 1'b1; cpu_waddr = 5'd20; cpu_wdata = 8'd9;
    #1 checkOutput("nonowner_ram_w", 32'(ram_w), 32'd0);
    checkOutput("owner_ram_waddr", 32'(ram_waddr), 32'(ld_waddr));
    tick();
    cpu_w = 1'b0;
    readCheck("ram20_unchanged", 1'b0, 5'd20, 8'd4);

    // Loader drops while CPU rises: one dead cycle, then CPU owns.
    applyStimulus(1'b0, 1'b1);
    cpu_w = 1'b1; cpu_waddr = 5'd20; cpu_wdata = 8'd9;
    tick();
    checkOutput("handover_idle_ld_gnt",  32'(ld_gnt),  32'd0);
    checkOutput("handover_idle_cpu_gnt", 32'(cpu_gnt), 32'd0);
    checkOutput("handover_idle_ram_w",   32'(ram_w),   32'd0);
    tick();
    checkOutput("handover_cpu_gnt", 32'(cpu_gnt), 32'd1);
    checkOutput("handover_cpu_en",  32'(cpu_en),  32'd1);
    exp_wr.addr = 5'd20;
    exp_wr.data = 8'd9;
    wr_q.push_back(exp_wr);
    tick();
    cpu_w = 1'b0;
    readCheck("cpu_write_20", 1'b1, 5'd20, 8'd9);

    // Preemption: loader holds while the CPU waits four cycles.
    applyStimulus(1'b0, 1'b0);
    tick();
    #1 checkOutput("idle_ram_raddr", 32'(ram_raddr), 32'd0);
    applyStimulus(1'b1, 1'b0);
    tick();
    checkOutput("pre_hold_ld_gnt", 32'(ld_gnt), 32'd1);
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < MH; i++) begin
      #1;
      checkOutput($sformatf("preempt_cycle%0d", i + 1), 32'(preempt), 32'(i == MH - 1));
      checkOutput($sformatf("hold_ld_gnt%0d", i + 1), 32'(ld_gnt), 32'd1);
      tick();
    end
    checkOutput("dead_ld_gnt",  32'(ld_gnt),  32'd0);
    checkOutput("dead_cpu_gnt", 32'(cpu_gnt), 32'd0);
    checkOutput("dead_preempt", 32'(preempt), 32'd0);
    tick();
    checkOutput("preempt_cpu_gnt", 32'(cpu_gnt), 32'd1);
    checkOutput("preempt_ld_gnt",  32'(ld_gnt),  32'd0);
    applyStimulus(1'b0, 1'b0);
    tick();

    // Simultaneous requests; CPU was served last.
    applyStimulus(1'b1, 1'b1);
    tick();
    checkOutput("simul_cpu_last_ld_gnt", 32'(ld_gnt), 32'd1);
    checkOutput("simul_cpu_last_cpu_en", 32'(cpu_en), 32'd0);
    applyStimulus(1'b0, 1'b0);
    tick();
    // Simultaneous requests; loader was served last.
    applyStimulus(1'b1, 1'b1);
    tick();
`ifdef ARB_ROUND_ROBIN_EN
    exp_ld = 1'b0; exp_cpu = 1'b1;
`else
    exp_ld = 1'b1; exp_cpu = 1'b0;
`endif
    checkOutput("simul_ld_last_ld_gnt",  32'(ld_gnt),  32'(exp_ld));
    checkOutput("simul_ld_last_cpu_gnt", 32'(cpu_gnt), 32'(exp_cpu));
    applyStimulus(1'b0, 1'b0);
    tick();

    // Asynchronous reset in the middle of CPU ownership.
    applyStimulus(1'b0, 1'b1);
    tick();
    checkOutput("own_cpu_gnt", 32'(cpu_gnt), 32'd1);
    cpu_w = 1'b1; cpu_waddr = 5'd7; cpu_wdata = 8'h37;
    #1 checkOutput("own_cpu_ram_w", 32'(ram_w), 32'd1);
    #1 reset = 1'b0;
    #1;
    checkOutput("async_cpu_gnt",   32'(cpu_gnt),   32'd0);
    checkOutput("async_cpu_en",    32'(cpu_en),    32'd0);
    checkOutput("async_ram_w",     32'(ram_w),     32'd0);
    checkOutput("async_ram_waddr", 32'(ram_waddr), 32'd0);
    cpu_w = 1'b0;
    tick();
    tick();
    #2 reset = 1'b1;
    checkOutput("release_before_edge", 32'(cpu_gnt), 32'd0);
    tick();
    checkOutput("post_reset_cpu_gnt", 32'(cpu_gnt), 32'd1);
    readCheck("ram7_untouched", 1'b1, 5'd7, 8'd0);
    applyStimulus(1'b0, 1'b0);
    tick();
    checkOutput("final_idle_cpu_gnt", 32'(cpu_gnt), 32'd0);
    checkOutput("pending_writes", 32'(wr_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
